// File: rtl/usb_pkg.sv
// Shared USB definitions used by usb_link and the endpoint receive buffer.
package usb_pkg;

    localparam int MAX_EP = 16;

    typedef logic [$clog2(MAX_EP)-1:0] ep_idx_t;

    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_SOF   = 4'b0101,
        PID_SETUP = 4'b1101,
        PID_DATA0 = 4'b0011,
        PID_DATA1 = 4'b1011,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010,
        PID_STALL = 4'b1110
    } pid_t;

endpackage

// File: rtl/usb_ep_ptr.sv
// One endpoint's read, committed-write and speculative-write pointers.
module usb_ep_ptr #(
    parameter int AW = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr,
    input  logic        commit,
    input  logic        rollback,
    input  logic        flush,
    input  logic        rd_inc,
    output logic [AW:0] rd_ptr,
    output logic [AW:0] cwr_ptr,
    output logic [AW:0] swr_ptr,
    output logic [AW:0] count
);

    logic [AW:0] swr_nxt;

    // Rollback and a new write can share a cycle (SOP restarting an open packet).
    assign swr_nxt = (rollback ? cwr_ptr : swr_ptr) + {{AW{1'b0}}, wr};
    assign count   = cwr_ptr - rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            cwr_ptr <= '0;
            swr_ptr <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            cwr_ptr <= '0;
            swr_ptr <= '0;
        end else begin
            rd_ptr  <= rd_ptr + {{AW{1'b0}}, rd_inc};
            swr_ptr <= swr_nxt;
            if (commit) cwr_ptr <= swr_nxt;
        end
    end

endmodule

// File: rtl/usb_ep_rx_buffer.sv
// Multi-endpoint receive buffer: speculative per-endpoint FIFOs with commit on a
// good EOP and rollback on CRC error, overflow, flush or a restarting SOP.
module usb_ep_rx_buffer
    import usb_pkg::*;
#(
    parameter int NUM_EP = 4,
    parameter int DEPTH  = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_lt_sop,
    input  logic                     rx_lt_eop,
    input  logic                     rx_lt_valid,
    output logic                     rx_lt_ready,
    input  logic [7:0]               rx_lt_data,
    input  logic [3:0]               rx_endp,
    input  logic                     crc16_err,
    input  logic [NUM_EP-1:0]        flush,
    input  logic [3:0]               rd_ep,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [7:0]               rd_data,
    output logic                     rd_eop,
    output logic [NUM_EP*(AW+1)-1:0] ep_count,
    output logic                     pkt_commit,
    output logic                     pkt_drop
);

    localparam int EPW = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
    localparam int PW  = AW + 1;

    logic [8:0]        mem [NUM_EP][DEPTH];
    logic [PW-1:0]     rd_ptr [NUM_EP];
    logic [PW-1:0]     cwr_ptr [NUM_EP];
    logic [PW-1:0]     swr_ptr [NUM_EP];
    logic [PW-1:0]     count [NUM_EP];
    logic [NUM_EP-1:0] wr, commit, rollback, rd_inc;

    logic    pkt_open, ovf;
    ep_idx_t cur_ep, new_ep;
    logic    beat, sop_b, eop_b, old_kill, new_open, new_valid, act, full;
    logic    ovf_now, good_eop, bad_eop, wr_ok, fk;
    logic [EPW-1:0] wr_idx, rd_idx;
    logic [PW-1:0]  wr_base, occ_rd, rd_cnt;
    logic [AW-1:0]  rd_addr;

    always_comb begin
        beat      = rx_lt_valid & rx_lt_ready;
        sop_b     = beat & rx_lt_sop;
        eop_b     = beat & rx_lt_eop;
        old_kill  = pkt_open & sop_b;
        new_ep    = sop_b ? rx_endp : cur_ep;
        new_open  = sop_b | pkt_open;
        new_valid = {1'b0, new_ep} < 5'(NUM_EP);

        wr_idx  = '0;
        wr_base = '0;
        occ_rd  = '0;
        fk      = 1'b0;
        for (int k = 0; k < NUM_EP; k++) begin
            if (new_ep == 4'(k)) begin
                wr_idx  = EPW'(k);
                // A restarting SOP on the same endpoint writes over the rolled-back space.
                wr_base = (old_kill && cur_ep == new_ep) ? cwr_ptr[k] : swr_ptr[k];
                occ_rd  = rd_ptr[k];
                fk      = flush[k];
            end
        end
        fk = fk & new_open;

        act      = beat & new_open & new_valid;
        full     = (wr_base - occ_rd) >= PW'(DEPTH);
        ovf_now  = (ovf & ~sop_b) | (act & full);
        good_eop = eop_b & act & ~ovf_now & ~crc16_err;
        bad_eop  = eop_b & new_open & ~good_eop;
        wr_ok    = act & ~full & ~bad_eop;

        for (int k = 0; k < NUM_EP; k++) begin
            wr[k]       = wr_ok & (new_ep == 4'(k));
            commit[k]   = good_eop & (new_ep == 4'(k));
            rollback[k] = (old_kill & (cur_ep == 4'(k))) | (bad_eop & (new_ep == 4'(k)));
            rd_inc[k]   = rd_ready & (rd_ep == 4'(k)) & (count[k] != '0);
        end
    end

    always_comb begin
        rd_idx  = '0;
        rd_cnt  = '0;
        rd_addr = '0;
        for (int k = 0; k < NUM_EP; k++) begin
            if (rd_ep == 4'(k)) begin
                rd_idx  = EPW'(k);
                rd_cnt  = count[k];
                rd_addr = rd_ptr[k][AW-1:0];
            end
        end
        rd_valid          = rd_cnt != '0;
        {rd_eop, rd_data} = mem[rd_idx][rd_addr];
    end

    for (genvar g = 0; g < NUM_EP; g++) begin : g_ep
        usb_ep_ptr #(.AW(AW)) u_ptr (
            .clk      (clk),
            .rst      (rst),
            .wr       (wr[g]),
            .commit   (commit[g]),
            .rollback (rollback[g]),
            .flush    (flush[g]),
            .rd_inc   (rd_inc[g]),
            .rd_ptr   (rd_ptr[g]),
            .cwr_ptr  (cwr_ptr[g]),
            .swr_ptr  (swr_ptr[g]),
            .count    (count[g])
        );
        assign ep_count[g*PW +: PW] = count[g];
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_idx][wr_base[AW-1:0]] <= {rx_lt_eop, rx_lt_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_open    <= 1'b0;
            cur_ep      <= '0;
            ovf         <= 1'b0;
            rx_lt_ready <= 1'b0;
            pkt_commit  <= 1'b0;
            pkt_drop    <= 1'b0;
        end else begin
            rx_lt_ready <= 1'b1;
            pkt_open    <= new_open & ~eop_b & ~fk;
            cur_ep      <= new_ep;
            ovf         <= ovf_now;
            pkt_commit  <= good_eop & ~fk;
            pkt_drop    <= old_kill | bad_eop | fk;
        end
    end

endmodule

// File: tb/tb_usb_ep_rx_buffer.sv
// Bench for usb_ep_rx_buffer: packet table plus hand-written corner sequences, read data
// checked against per-endpoint queues of expected {eop,data}.
module tb_usb_ep_rx_buffer;

    localparam int NUM_EP = 4;
    localparam int DEPTH  = 64;
    localparam int PW     = 7;

    logic                   clk;
    logic                   rst;
    logic                   rx_lt_sop, rx_lt_eop, rx_lt_valid, rx_lt_ready;
    logic [7:0]             rx_lt_data;
    logic [3:0]             rx_endp;
    logic                   crc16_err;
    logic [NUM_EP-1:0]      flush;
    logic [3:0]             rd_ep;
    logic                   rd_valid, rd_ready, rd_eop;
    logic [7:0]             rd_data;
    logic [NUM_EP*PW-1:0]   ep_count;
    logic                   pkt_commit, pkt_drop;

    usb_ep_rx_buffer #(.NUM_EP(NUM_EP), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_lt_sop   (rx_lt_sop),
        .rx_lt_eop   (rx_lt_eop),
        .rx_lt_valid (rx_lt_valid),
        .rx_lt_ready (rx_lt_ready),
        .rx_lt_data  (rx_lt_data),
        .rx_endp     (rx_endp),
        .crc16_err   (crc16_err),
        .flush       (flush),
        .rd_ep       (rd_ep),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .rd_eop      (rd_eop),
        .ep_count    (ep_count),
        .pkt_commit  (pkt_commit),
        .pkt_drop    (pkt_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic [8:0] expq [NUM_EP][$];

    typedef struct {
        int ep;
        int len;
        int base;
        bit crc;
        bit exp_commit;
        bit exp_drop;
        int cnt_ep;
        int exp_cnt;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] cnt(input int ep);
        return 32'(ep_count[ep*PW +: PW]);
    endfunction

    task automatic beat(input bit sop, input bit eop, input int ep, input logic [7:0] d, input bit crc);
        rx_lt_valid = 1'b1;
        rx_lt_sop   = sop;
        rx_lt_eop   = eop;
        rx_endp     = 4'(ep);
        rx_lt_data  = d;
        crc16_err   = crc & eop;
        @(posedge clk);
        #1;
        rx_lt_valid = 1'b0;
        rx_lt_sop   = 1'b0;
        rx_lt_eop   = 1'b0;
        crc16_err   = 1'b0;
    endtask

    task automatic send_pkt(input int ep, input int len, input int base, input bit crc);
        for (int i = 0; i < len; i++)
            beat(i == 0, i == len - 1, ep, 8'(base + i), crc);
    endtask

    task automatic push_pkt(input int ep, input int len, input int base);
        for (int i = 0; i < len; i++) begin
            bit e;
            e = (i == len - 1);
            expq[ep].push_back({e, 8'(base + i)});
        end
    endtask

    task automatic drain(input int ep, input int budget);
        int n;
        n = 0;
        rd_ep    = 4'(ep);
        rd_ready = 1'b1;
        while (expq[ep].size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        rd_ready = 1'b0;
        check($sformatf("drain_ep%0d_left", ep), 32'(expq[ep].size()), 0);
        check($sformatf("drain_ep%0d_rd_valid", ep), 32'(rd_valid), 0);
        check($sformatf("drain_ep%0d_count", ep), cnt(ep), 0);
    endtask

    // Scoreboard: every accepted read byte must match the oldest expected byte of its endpoint.
    always @(negedge clk) begin
        if (!rst && rd_valid && rd_ready) begin
            int e;
            e = int'(rd_ep);
            if (e < NUM_EP && expq[e].size() > 0) begin
                logic [8:0] x;
                x = expq[e].pop_front();
                check($sformatf("rd_byte_ep%0d", e), 32'({rd_eop, rd_data}), 32'(x));
            end else begin
                check($sformatf("rd_unexpected_ep%0d", e), 32'({rd_eop, rd_data}), 32'hFFFF_FFFF);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_chk=%0d n_fail=%0d", n_chk, n_fail);
        $fatal(1);
    end

    initial begin
        tbl[0] = '{ep: 1, len: 7, base: 8'h01, crc: 0, exp_commit: 1, exp_drop: 0, cnt_ep: 1, exp_cnt: 7};
        tbl[1] = '{ep: 2, len: 5, base: 8'h20, crc: 1, exp_commit: 0, exp_drop: 1, cnt_ep: 2, exp_cnt: 0};
        tbl[2] = '{ep: 2, len: 3, base: 8'h30, crc: 0, exp_commit: 1, exp_drop: 0, cnt_ep: 2, exp_cnt: 3};
        tbl[3] = '{ep: 9, len: 2, base: 8'h90, crc: 0, exp_commit: 0, exp_drop: 1, cnt_ep: 1, exp_cnt: 7};
        tbl[4] = '{ep: 0, len: 1, base: 8'hA0, crc: 0, exp_commit: 1, exp_drop: 0, cnt_ep: 0, exp_cnt: 1};

        rst = 1'b1;
        rx_lt_sop = 1'b0; rx_lt_eop = 1'b0; rx_lt_valid = 1'b0;
        rx_lt_data = 8'h00; rx_endp = 4'h0; crc16_err = 1'b0;
        flush = '0; rd_ep = 4'h0; rd_ready = 1'b0;

        #2;
        check("reset_ready", 32'(rx_lt_ready), 0);
        check("reset_rd_valid", 32'(rd_valid), 0);
        check("reset_ep_count", 32'(ep_count), 0);
        check("reset_pulses", 32'({pkt_commit, pkt_drop}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("release_ready_low", 32'(rx_lt_ready), 0);
        @(posedge clk);
        #1;
        check("release_ready_high", 32'(rx_lt_ready), 1);

        // Table-driven packets.
        for (int t = 0; t < 5; t++) begin
            send_pkt(tbl[t].ep, tbl[t].len, tbl[t].base, tbl[t].crc);
            check($sformatf("tbl%0d_commit", t), 32'(pkt_commit), 32'(tbl[t].exp_commit));
            check($sformatf("tbl%0d_drop", t), 32'(pkt_drop), 32'(tbl[t].exp_drop));
            check($sformatf("tbl%0d_count", t), cnt(tbl[t].cnt_ep), 32'(tbl[t].exp_cnt));
            if (tbl[t].exp_commit) push_pkt(tbl[t].ep, tbl[t].len, tbl[t].base);
        end
        rd_ep = 4'd9;
        #1;
        check("rd_ep_out_of_range", 32'(rd_valid), 0);
        drain(1, 50);
        drain(2, 50);
        drain(0, 50);

        // Overflow: 60 committed bytes leave room for only 4 of 8.
        send_pkt(0, 60, 8'h00, 0);
        check("fill_commit", 32'(pkt_commit), 1);
        push_pkt(0, 60, 8'h00);
        send_pkt(0, 8, 8'hC0, 0);
        check("ovf_drop", 32'(pkt_drop), 1);
        check("ovf_commit", 32'(pkt_commit), 0);
        check("ovf_count", cnt(0), 60);
        drain(0, 200);

        // Wrap with concurrent draining on EP3.
        rd_ep    = 4'd3;
        rd_ready = 1'b1;
        for (int p = 0; p < 3; p++) begin
            send_pkt(3, 40, 8'h10 + p * 40, 0);
            check($sformatf("wrap_commit%0d", p), 32'(pkt_commit), 1);
            push_pkt(3, 40, 8'h10 + p * 40);
        end
        drain(3, 300);

        // SOP to EP1 while EP0 is open.
        beat(1, 0, 0, 8'hE0, 0);
        beat(0, 0, 0, 8'hE1, 0);
        beat(1, 0, 1, 8'h61, 0);
        check("restart_drop", 32'(pkt_drop), 1);
        beat(0, 0, 1, 8'h62, 0);
        beat(0, 1, 1, 8'h63, 0);
        check("restart_commit", 32'(pkt_commit), 1);
        check("restart_ep0_count", cnt(0), 0);
        check("restart_ep1_count", cnt(1), 3);
        push_pkt(1, 3, 8'h61);

        // Flush EP1 after one byte has been read.
        rd_ep    = 4'd1;
        rd_ready = 1'b1;
        @(posedge clk);
        #1;
        rd_ready = 1'b0;
        check("preflush_count", cnt(1), 2);
        flush = 4'b0010;
        @(posedge clk);
        #1;
        flush = '0;
        expq[1].delete();
        check("flush_count", cnt(1), 0);
        check("flush_rd_valid", 32'(rd_valid), 0);

        // Flush an open packet: drop pulse, later EOP ignored.
        beat(1, 0, 2, 8'h70, 0);
        beat(0, 0, 2, 8'h71, 0);
        flush = 4'b0100;
        @(posedge clk);
        #1;
        flush = '0;
        check("flush_open_drop", 32'(pkt_drop), 1);
        beat(0, 1, 2, 8'h72, 0);
        check("flush_late_eop_pulses", 32'({pkt_commit, pkt_drop}), 0);
        check("flush_late_eop_count", cnt(2), 0);

        // Reset mid-packet and mid-read.
        send_pkt(1, 5, 8'h50, 0);
        check("prereset_commit", 32'(pkt_commit), 1);
        push_pkt(1, 5, 8'h50);
        beat(1, 0, 0, 8'hD0, 0);
        beat(0, 0, 0, 8'hD1, 0);
        rd_ep    = 4'd1;
        rd_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rd_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_ready", 32'(rx_lt_ready), 0);
        check("midrst_ep_count", 32'(ep_count), 0);
        check("midrst_rd_valid", 32'(rd_valid), 0);
        repeat (3) @(posedge clk);
        #1;
        check("held_rst_ready", 32'(rx_lt_ready), 0);
        check("held_rst_pulses", 32'({pkt_commit, pkt_drop}), 0);
        rst = 1'b0;
        for (int e = 0; e < NUM_EP; e++) expq[e].delete();
        @(posedge clk);
        #1;
        check("postrst_ready", 32'(rx_lt_ready), 1);
        beat(0, 1, 0, 8'hD2, 0);
        check("postrst_orphan_eop", 32'({pkt_commit, pkt_drop}), 0);
        check("postrst_ep0_count", cnt(0), 0);
        send_pkt(1, 3, 8'h80, 0);
        check("postrst_commit", 32'(pkt_commit), 1);
        check("postrst_count", cnt(1), 3);
        push_pkt(1, 3, 8'h80);
        drain(1, 50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
